mem_responder: RTL
==================

# mem_responder

Memory-side responder for the CPU's 64-bit memory bus, sitting between the CPU's `address`/`datao`/`rw` outputs and its `data` input. Holds a word-addressed program/data RAM, boot-loads it from a valid/ready stream while the CPU is held, then serves CPU reads and writes. An optional memory-mapped output port forwards CPU writes to a downstream peripheral through a one-entry handshake buffer.

## Interface
Parameters:
- DEPTH, 256: RAM size in 64-bit words; power of two, 16 to 65536.
- IO_ADDR, 64'hFFFF_FFFF_FFFF_FFF0: address of the output data port; IO_ADDR+1 is the status word.

Ports:
- clock  in  1  single clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- address  in  64  CPU word address.
- wdata  in  64  CPU write data; connects to CPU `datao`.
- rw  in  1  1 = read, 0 = write.
- rdata  out  64  read data; connects to CPU `data`.
- load_valid  in  1  boot stream beat valid.
- load_data  in  64  boot stream word.
- load_last  in  1  final beat marker.
- load_ready  out  1  high in LOAD state.
- cpu_run  out  1  high in RUN; CPU reset is driven from ~cpu_run.
- io_valid  out  1  output port word available.
- io_data  out  64  output port word.
- io_ready  in  1  peripheral accepts word.

## Operation
- States: LOAD (reset state) and RUN.
- LOAD: load_ready=1, cpu_run=0, CPU bus ignored. Each cycle with load_valid: mem[load_ptr] <= load_data, load_ptr += 1. Go to RUN after the beat with load_last=1, or after the beat written to DEPTH-1, whichever comes first. load_ptr does not wrap.
- RUN: load_ready=0, cpu_run=1; load inputs ignored. Stays in RUN until reset.
- In range means address < DEPTH; the index is address[log2(DEPTH)-1:0].
- Read (rw=1): rdata <= mem[index] for in-range addresses. IO_ADDR+1 returns {62'b0, io_overflow, io_valid}. Every other address returns 0.
- Write (rw=0):
  - In range: mem[index] <= wdata on every cycle rw is 0. Repeats are idempotent.
  - IO_ADDR: pushes once per write run. A write run starts on a cycle with rw=0 where the previous cycle had rw=1 or a different address.
  - If the buffer is empty, or is being drained in the same cycle (io_valid & io_ready), the word is accepted. Otherwise it is dropped and sticky io_overflow is set.
  - All other addresses: ignored.
- Reset, including mid-load or mid-run: state to LOAD, load_ptr=0, rdata=0, io_valid=0, io_overflow=0, edge-detect history to "previous rw=1". RAM contents are preserved.

## Timing
- Read latency is 1 cycle: the address is sampled at posedge N and rdata is valid after posedge N. rdata holds its value in LOAD and on write cycles.
- A write to address X in cycle N is visible to a read of X sampled in cycle N+1. There is no write-before-read bypass within the same cycle, since rw selects only one operation.
- Boot load takes 1 beat per cycle at full rate. cpu_run rises the cycle after the final accepted beat.
- Output port:
  - io_valid rises the cycle after an accepted push.
  - io_data is stable while io_valid & ~io_ready.
  - The word leaves on a cycle with io_valid & io_ready.
  - A push and a drain in the same cycle leaves io_valid=1 with the new data.
- io_overflow clears only on reset.

## Configuration
- MEM_IO_EN defined: the output port and status word exist as described above.
- MEM_IO_EN undefined:
  - No output buffer is built. io_valid=0 and io_data=0 constantly; io_ready is ignored.
  - IO_ADDR and IO_ADDR+1 behave as ordinary out-of-range addresses: reads return 0, writes are ignored.

## Structure
- Package `cpu_bus_pkg` holds:
  - the state enum (LOAD, RUN);
  - RW_READ/RW_WRITE constants;
  - the default IO_ADDR;
  - the STATUS offset (1) and status bit positions (FULL=0, OVERFLOW=1).
- Sub-module `io_out_buffer`: a one-entry valid/ready register with push, overflow flag and reset. It is instantiated only under MEM_IO_EN.

## Test plan
- Load 4 beats 0x11,0x22,0x33,0x44 (last on the 4th beat) -> cpu_run=1 the next cycle; reads of addr 0..3 return 0x11..0x44 one cycle after each address.
- Stream DEPTH beats with load_last=0 -> auto-transition to RUN after beat DEPTH-1; load_ready=0 afterward and a further beat is not written.
- RUN: write 0xDEAD to addr 5 with rw=0 held 3 cycles, then read addr 5 -> 0xDEAD. Read addr DEPTH -> 0.
- MEM_IO_EN: write 0xA5 to IO_ADDR with rw=0 held 2 cycles and io_ready=0 -> exactly one push; io_valid=1, io_data=0xA5. A second write run of 0x5A -> dropped; status read returns 2'b11. Raise io_ready -> io_valid=0.
- MEM_IO_EN: with io_valid=1 and io_ready=1, start a write of 0x77 in the same cycle -> io_valid stays 1, io_data=0x77, io_overflow stays 0.
- Reset asserted mid-RUN -> LOAD, cpu_run=0, rdata=0, io_valid=0. After reloading 1 beat with last=1, addr 5 still reads 0xDEAD.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU memory bus: FSM state encoding, rw
// polarity, default output-port address and status-word layout.
package cpu_bus_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [63:0] IO_ADDR_DEFAULT = 64'hFFFF_FFFF_FFFF_FFF0;

  // The status word sits one word above the output data port
  localparam logic [63:0] STATUS_OFFSET = 64'd1;
  localparam int unsigned STATUS_FULL_BIT     = 0;
  localparam int unsigned STATUS_OVERFLOW_BIT = 1;

  function automatic logic [63:0] status_word(input logic full, input logic overflow);
    logic [63:0] w;
    w = '0;
    w[STATUS_FULL_BIT]     = full;
    w[STATUS_OVERFLOW_BIT] = overflow;
    return w;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Bundle of the CPU bus, boot-load stream and output-port handshake seen by
// mem_responder. The slave modport is the responder side.
interface mem_responder_if;
  logic [63:0] address;
  logic [63:0] wdata;
  logic        rw;
  logic [63:0] rdata;
  logic        load_valid;
  logic [63:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        cpu_run;
  logic        io_valid;
  logic [63:0] io_data;
  logic        io_ready;

  modport master (
    output address, wdata, rw, load_valid, load_data, load_last, io_ready,
    input  rdata, load_ready, cpu_run, io_valid, io_data
  );

  modport slave (
    input  address, wdata, rw, load_valid, load_data, load_last, io_ready,
    output rdata, load_ready, cpu_run, io_valid, io_data
  );
endinterface

// File: rtl/mem_responder_io_out_buffer.sv
// One-entry valid/ready holding register for the memory-mapped output port.
// A push is accepted when the slot is empty or is draining in the same cycle;
// otherwise the word is dropped and a sticky overflow flag is raised.
module io_out_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_push,
  input  logic [63:0] i_data,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [63:0] o_data,
  output logic        o_overflow
);

  logic        r_valid;
  logic [63:0] r_data;
  logic        r_overflow;
  logic        w_accept;

  assign w_accept = i_push & (~r_valid | i_ready);

  // Slot occupancy and sticky overflow
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
      if (i_push && !w_accept) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Payload is only replaced on an accepted push, so it holds while stalled
  always_ff @(posedge clock) begin
    if (reset) begin
      r_data <= '0;
    end else if (w_accept) begin
      r_data <= i_data;
    end
  end

  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the 64-bit CPU bus: word RAM boot-loaded from a
// valid/ready stream while the CPU is held, then serving CPU reads/writes.
// Build option MEM_IO_EN adds the memory-mapped output port at IO_ADDR and
// its status word at IO_ADDR+1; without it those addresses are plain
// out-of-range locations.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_LOAD | boot stream accepted into RAM, CPU held, CPU bus ignored
// ST_RUN  | CPU released, RAM/IO serve the CPU bus until reset
module mem_responder
  import cpu_bus_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter logic [63:0] IO_ADDR = IO_ADDR_DEFAULT
) (
  input logic           clock,
  input logic           reset,
  mem_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [AW-1:0] r_load_ptr;
  logic [63:0] r_mem [DEPTH];
  logic [63:0] r_rdata;

  logic          w_in_range;
  logic [AW-1:0] w_index;
  logic          w_load_beat;
  logic          w_load_done;
  logic          w_cpu_rd;
  logic          w_load_ready;
  logic          w_cpu_run;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_waddr;
  logic [63:0]   w_mem_wdata;
  logic [63:0]   w_rd_other;

  assign w_in_range  = bus.address < 64'(DEPTH);
  assign w_index     = bus.address[AW-1:0];
  assign w_load_beat = (r_state == ST_LOAD) && bus.load_valid;
  assign w_load_done = w_load_beat && (bus.load_last || (r_load_ptr == AW'(DEPTH - 1)));
  assign w_cpu_rd    = (r_state == ST_RUN) && (bus.rw == RW_READ);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, handshake outputs and the single RAM write port mux
  always_comb begin
    w_state_nxt  = r_state;
    w_load_ready = 1'b0;
    w_cpu_run    = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_waddr  = w_index;
    w_mem_wdata  = bus.wdata;
    unique case (r_state)
      ST_LOAD: begin
        w_load_ready = 1'b1;
        if (w_load_beat) begin
          w_mem_we    = 1'b1;
          w_mem_waddr = r_load_ptr;
          w_mem_wdata = bus.load_data;
          if (w_load_done) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        w_cpu_run = 1'b1;
        if ((bus.rw == RW_WRITE) && w_in_range) begin
          w_mem_we = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_LOAD;
      end
    endcase
  end

  // Boot pointer; it never needs to wrap because loading ends at DEPTH-1
  always_ff @(posedge clock) begin
    if (reset) begin
      r_load_ptr <= '0;
    end else if (w_load_beat) begin
      r_load_ptr <= r_load_ptr + 1'b1;
    end
  end

  // RAM array; contents deliberately survive reset
  always_ff @(posedge clock) begin
    if (!reset && w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Registered read data, held through LOAD and write cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_cpu_rd) begin
      if (w_in_range) begin
        r_rdata <= r_mem[w_index];
      end else begin
        r_rdata <= w_rd_other;
      end
    end
  end

`ifdef MEM_IO_EN
  logic        r_prev_rw;
  logic [63:0] r_prev_addr;
  logic        w_run_start;
  logic        w_io_push;
  logic        w_io_valid;
  logic [63:0] w_io_data;
  logic        w_io_overflow;

  // A held write to IO_ADDR pushes only once, on the first cycle of the run
  assign w_run_start = (r_prev_rw == RW_READ) || (r_prev_addr != bus.address);
  assign w_io_push   = (r_state == ST_RUN) && (bus.rw == RW_WRITE) &&
                       (bus.address == IO_ADDR) && w_run_start;

  // Previous-cycle CPU bus history for write-run edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev_rw   <= RW_READ;
      r_prev_addr <= '0;
    end else if (r_state == ST_RUN) begin
      r_prev_rw   <= bus.rw;
      r_prev_addr <= bus.address;
    end
  end

  // Status word at IO_ADDR+1, everything else outside the RAM reads zero
  always_comb begin
    w_rd_other = '0;
    if (bus.address == (IO_ADDR + STATUS_OFFSET)) begin
      w_rd_other = status_word(w_io_valid, w_io_overflow);
    end
  end

  io_out_buffer u_io_out_buffer (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_io_push),
    .i_data     (bus.wdata),
    .i_ready    (bus.io_ready),
    .o_valid    (w_io_valid),
    .o_data     (w_io_data),
    .o_overflow (w_io_overflow)
  );

  assign bus.io_valid = w_io_valid;
  assign bus.io_data  = w_io_data;
`else
  assign w_rd_other   = '0;
  assign bus.io_valid = 1'b0;
  assign bus.io_data  = '0;
`endif

  assign bus.rdata      = r_rdata;
  assign bus.load_ready = w_load_ready;
  assign bus.cpu_run    = w_cpu_run;

endmodule
